// File: rtl/multicycle_pkg.sv
// Shared opcodes, instruction classes and per-class last-step numbers for the
// multicycle step sequencer.
package multicycle_pkg;

    localparam logic [4:0] OP_ALU   = 5'b00000;
    localparam logic [4:0] OP_LHI   = 5'b00001;
    localparam logic [4:0] OP_LLI   = 5'b00010;
    localparam logic [4:0] OP_LDRRI = 5'b00011;
    localparam logic [4:0] OP_LDRRR = 5'b00100;
    localparam logic [4:0] OP_STRRI = 5'b00101;
    localparam logic [4:0] OP_STRRR = 5'b00110;
    localparam logic [4:0] OP_ADDI  = 5'b00111;
    localparam logic [4:0] OP_SUBI  = 5'b01000;
    localparam logic [4:0] OP_MOV   = 5'b01011;
    localparam logic [4:0] OP_JMP   = 5'b10000;
    localparam logic [4:0] OP_JALRL = 5'b10001;
    localparam logic [4:0] OP_JALRR = 5'b10010;
    localparam logic [4:0] OP_JR    = 5'b10011;
    localparam logic [4:0] OP_BR0   = 5'b11000;
    localparam logic [4:0] OP_BR1   = 5'b11001;
    localparam logic [4:0] OP_SYS   = 5'b11100;

    // InsL sub-functions for the shared opcodes
    localparam logic [1:0] FN_LDRRR = 2'b00;
    localparam logic [1:0] FN_STRRR = 2'b00;
    localparam logic [1:0] FN_CMP   = 2'b01;
    localparam logic [1:0] FN_OUTR  = 2'b00;
    localparam logic [1:0] FN_HLT   = 2'b01;

    typedef enum logic [2:0] {
        CLS_NOP, CLS_3, CLS_4, CLS_ST, CLS_LD, CLS_HLT, CLS_ILL
    } cls_e;

    typedef enum logic {ST_RUN, ST_HALT} state_e;

    localparam int unsigned LAST_NOP = 1;
    localparam int unsigned LAST_3   = 2;
    localparam int unsigned LAST_4   = 3;
    localparam int unsigned LAST_ST  = 3;
    localparam int unsigned LAST_LD  = 4;
    localparam int unsigned LAST_HLT = 1;
    localparam int unsigned LAST_ILL = 1;
    localparam int unsigned MEM_STEP = 3;

    function automatic int unsigned last_step(input cls_e c);
        case (c)
            CLS_3:   return LAST_3;
            CLS_4:   return LAST_4;
            CLS_ST:  return LAST_ST;
            CLS_LD:  return LAST_LD;
            CLS_HLT: return LAST_HLT;
            CLS_ILL: return LAST_ILL;
            default: return LAST_NOP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_class_dec.sv
// Combinational instruction-class decoder from InsM/InsL.
module multicycle_class_dec
    import multicycle_pkg::*;
(
    input  logic [4:0] ins_m_i,
    input  logic [1:0] ins_l_i,
    output cls_e       cls_o
);

    always_comb begin
        cls_o = CLS_ILL;
        case (ins_m_i)
            OP_ALU, OP_ADDI, OP_SUBI, OP_JALRL, OP_JALRR: cls_o = CLS_4;
            OP_LHI, OP_LLI, OP_MOV, OP_JMP, OP_JR, OP_BR0, OP_BR1: cls_o = CLS_3;
            OP_LDRRI: cls_o = CLS_LD;
            OP_STRRI: cls_o = CLS_ST;
            OP_LDRRR: begin
                if (ins_l_i == FN_LDRRR) cls_o = CLS_LD;
            end
            OP_STRRR: begin
                if (ins_l_i == FN_STRRR)    cls_o = CLS_ST;
                else if (ins_l_i == FN_CMP) cls_o = CLS_3;
            end
            OP_SYS: begin
                if (ins_l_i == FN_OUTR)     cls_o = CLS_3;
                else if (ins_l_i == FN_HLT) cls_o = CLS_HLT;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_step_ctrl.sv
// Step counter / end-of-instruction strobe / halt latch for the multicycle core.
// Define MEM_WAIT_EN to let Mem_Rdy stall memory steps; otherwise Mem_Rdy is ignored.
module multicycle_step_ctrl
    import multicycle_pkg::*;
#(
    parameter int unsigned CNT_W        = 3,
    parameter bit          ILLEGAL_HALT = 1'b0
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic [4:0]       InsM,
    input  logic [1:0]       InsL,
    input  logic             Mem_Rdy,
    output logic [CNT_W-1:0] Cnt,
    output logic             Buff_PC,
    output logic             IR_Load,
    output logic             Mem_Req,
    output logic             Done,
    output logic             Illegal
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cls_e             cls_q, cls_d;
    logic             illegal_q, illegal_d;
    cls_e             dec_cls;
    cls_e             cls_cur;
    logic             stall;
    logic             mem_rdy;

`ifdef MEM_WAIT_EN
    assign mem_rdy = Mem_Rdy;
`else
    logic unused_mem_rdy;
    assign unused_mem_rdy = Mem_Rdy;
    assign mem_rdy        = 1'b1;
`endif

    multicycle_class_dec u_dec (
        .ins_m_i (InsM),
        .ins_l_i (InsL),
        .cls_o   (dec_cls)
    );

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            cls_q     <= CLS_NOP;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cls_q     <= cls_d;
            illegal_q <= illegal_d;
        end
    end

    // Step advance, class capture at decode, halt entry on the last step.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cls_d     = cls_q;
        illegal_d = illegal_q;
        if (state_q == ST_RUN && !stall) begin
            if (cnt_q == CNT_W'(1)) begin
                cls_d = dec_cls;
                if (dec_cls == CLS_ILL) illegal_d = 1'b1;
            end
            if (Buff_PC) begin
                cnt_d = '0;
                if (cls_cur == CLS_HLT || (ILLEGAL_HALT && cls_cur == CLS_ILL))
                    state_d = ST_HALT;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Decode step uses the live decoder, later steps the registered class.
    always_comb begin
        Buff_PC = 1'b0;
        IR_Load = 1'b0;
        Mem_Req = 1'b0;
        stall   = 1'b0;
        cls_cur = cls_q;
        if (state_q == ST_RUN && !Rst) begin
            if (cnt_q == CNT_W'(1)) cls_cur = dec_cls;
            Mem_Req = (cnt_q == '0) ||
                      (cnt_q == CNT_W'(MEM_STEP) && (cls_q == CLS_LD || cls_q == CLS_ST));
            stall   = Mem_Req && !mem_rdy;
            IR_Load = (cnt_q == CNT_W'(1));
            Buff_PC = (cnt_q != '0) && (cnt_q == CNT_W'(last_step(cls_cur))) && !stall;
        end
    end

    assign Cnt     = cnt_q;
    assign Done    = (state_q == ST_HALT);
    assign Illegal = illegal_q;

endmodule
